ccd_line_ctrl: RTL and testbench

- Run controller that sequences the TCD1209D CCD timing driver.
- Latches line-rate and mode configuration, and starts and stops acquisition.
- Converts asynchronous external triggers into single line launches, and limits acquisition to N lines per frame.
- Sits between the register/command interface and the driver. It drives the driver's triggerMode, extTrigger and f_cnt inputs and observes its os_tvalid output.

---
 rtl/ccd_pkg.sv | 13 +
 rtl/ccd_trig_sync.sv | 20 ++
 rtl/ccd_line_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ccd_line_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccd_pkg.sv
// Shared types and timing constants for the TCD1209D run controller.
package ccd_pkg;

  typedef enum logic [2:0] {
    IDLE, INT_RUN, EXT_WAIT, LAUNCH, EXT_LINE, GUARD, DRAIN
  } ccd_state_e;

  localparam int          LINE_MIN_CLKS = 2125;
  localparam logic [24:0] F_CNT_MAX     = 25'd19997875;
  localparam int          CCD_LOAD_CLKS = 35;
  localparam int          CCD_PIXELS    = 2088;

endpackage

// File: rtl/ccd_trig_sync.sv
// Two-flop synchronizer for the external trigger with a one-cycle rising-edge pulse.
module ccd_trig_sync (
  input  logic pxl_clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [2:0] sr;

  always_ff @(posedge pxl_clk) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], async_in};
  end

  assign level = sr[1];
  assign rise  = sr[1] & ~sr[2];

endmodule

// File: rtl/ccd_line_ctrl.sv
// Run controller for the TCD1209D timing driver: config shadowing, frame start/stop,
// external trigger launch with one-deep pending, and lines-per-frame limiting.
module ccd_line_ctrl #(
  parameter logic [24:0] F_CNT_MAX = ccd_pkg::F_CNT_MAX,
  parameter int          GUARD_CYC = 4,
  parameter int          LINES_W   = 16
) (
  input  logic               pxl_clk,
  input  logic               rst_n,
  input  logic               cfg_wr,
  input  logic               cfg_ext_mode,
  input  logic [24:0]        cfg_f_cnt,
  input  logic [LINES_W-1:0] cfg_lines,
  input  logic               start,
  input  logic               stop,
  input  logic               ext_trig,
  input  logic               os_tvalid,
  output logic               drv_trigger_mode,
  output logic               drv_ext_trigger,
  output logic [24:0]        drv_f_cnt,
  output logic               busy,
  output logic [LINES_W-1:0] line_cnt,
  output logic               frame_done,
  output logic               trig_overrun
);

  import ccd_pkg::*;

  localparam int TMR_W = 8;
  // Drain timeout covers the driver's load phase plus a small margin.
  localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(CCD_LOAD_CLKS + 4);
  localparam logic [TMR_W-1:0] GUARD_LAST = TMR_W'(GUARD_CYC - 1);

  ccd_state_e         state;
  logic               mode_sh;
  logic [24:0]        f_cnt_sh;
  logic [LINES_W-1:0] lines_sh, lines_act;
  logic               pend, stop_seen, drain_live, tv_q, trig_req;
  logic [TMR_W-1:0]   tmr;

  wire tv_rise = os_tvalid & ~tv_q;
  wire tv_fall = tv_q & ~os_tvalid;

  function automatic logic [LINES_W-1:0] sat_inc(input logic [LINES_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ccd_trig_sync u_trig_sync (
    .pxl_clk  (pxl_clk),
    .rst_n    (rst_n),
    .async_in (ext_trig),
    .level    (drv_ext_trigger),
    .rise     (trig_req)
  );

  always_ff @(posedge pxl_clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      drv_trigger_mode <= 1'b1;
      drv_f_cnt        <= '0;
      busy             <= 1'b0;
      line_cnt         <= '0;
      frame_done       <= 1'b0;
      trig_overrun     <= 1'b0;
      mode_sh          <= 1'b0;
      f_cnt_sh         <= '0;
      lines_sh         <= '0;
      lines_act        <= '0;
      pend             <= 1'b0;
      stop_seen        <= 1'b0;
      drain_live       <= 1'b0;
      tmr              <= '0;
      tv_q             <= 1'b0;
    end else begin
      frame_done   <= 1'b0;
      trig_overrun <= 1'b0;
      tv_q         <= os_tvalid;

      if (cfg_wr) begin
        mode_sh  <= cfg_ext_mode;
        f_cnt_sh <= (cfg_f_cnt > F_CNT_MAX) ? F_CNT_MAX : cfg_f_cnt;
        lines_sh <= cfg_lines;
      end

      // Requests arriving while a launched line is in flight queue one deep.
      if (trig_req && (state == LAUNCH || state == EXT_LINE || state == GUARD)) begin
        if (pend) trig_overrun <= 1'b1;
        else      pend         <= 1'b1;
      end

      case (state)
        IDLE: begin
          drv_trigger_mode <= 1'b1;
          if (start) begin
            drv_f_cnt        <= f_cnt_sh;
            lines_act        <= lines_sh;
            line_cnt         <= '0;
            busy             <= 1'b1;
            pend             <= 1'b0;
            stop_seen        <= 1'b0;
            drv_trigger_mode <= mode_sh;
            state            <= mode_sh ? EXT_WAIT : INT_RUN;
          end
        end
        INT_RUN: begin
          if (tv_fall) line_cnt <= sat_inc(line_cnt);
          if (stop || (tv_rise && lines_act != '0 && line_cnt == lines_act - 1'b1)) begin
            drv_trigger_mode <= 1'b1;
            drain_live       <= os_tvalid;
            tmr              <= '0;
            state            <= DRAIN;
          end
        end
        EXT_WAIT: begin
          if (stop) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (trig_req || pend) begin
            pend             <= trig_req & pend;
            drv_trigger_mode <= 1'b0;
            state            <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (stop) stop_seen <= 1'b1;
          drv_trigger_mode <= 1'b1;
          state            <= EXT_LINE;
        end
        EXT_LINE: begin
          if (stop) stop_seen <= 1'b1;
          if (tv_fall) begin
            line_cnt <= sat_inc(line_cnt);
            tmr      <= '0;
            state    <= GUARD;
          end
        end
        GUARD: begin
          if (stop) stop_seen <= 1'b1;
          if (tmr == GUARD_LAST) begin
            if ((lines_act != '0 && line_cnt == lines_act) || stop_seen || stop) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              state <= EXT_WAIT;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        DRAIN: begin
          if (os_tvalid) drain_live <= 1'b1;
          if (tv_fall) begin
            line_cnt   <= sat_inc(line_cnt);
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (!drain_live && !os_tvalid) begin
            // Stopped between lines: give up once no line has started in time.
            if (tmr == DRAIN_LAST) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccd_line_ctrl.sv
// Directed bench for ccd_line_ctrl with a behavioural TCD1209D driver model.
module tb_ccd_line_ctrl;
  import ccd_pkg::*;

  localparam int LW = 16;

  logic          pxl_clk = 1'b0;
  logic          rst_n = 1'b0, cfg_wr = 1'b0, cfg_ext_mode = 1'b0;
  logic          start = 1'b0, stop = 1'b0, ext_trig = 1'b0;
  logic [24:0]   cfg_f_cnt = '0;
  logic [LW-1:0] cfg_lines = '0;
  logic          os_tvalid;
  logic          drv_trigger_mode, drv_ext_trigger, busy, frame_done, trig_overrun;
  logic [24:0]   drv_f_cnt;
  logic [LW-1:0] line_cnt;

  ccd_line_ctrl dut (
    .pxl_clk(pxl_clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_ext_mode(cfg_ext_mode),
    .cfg_f_cnt(cfg_f_cnt), .cfg_lines(cfg_lines), .start(start), .stop(stop),
    .ext_trig(ext_trig), .os_tvalid(os_tvalid), .drv_trigger_mode(drv_trigger_mode),
    .drv_ext_trigger(drv_ext_trigger), .drv_f_cnt(drv_f_cnt), .busy(busy),
    .line_cnt(line_cnt), .frame_done(frame_done), .trig_overrun(trig_overrun)
  );

  always #25 pxl_clk = ~pxl_clk;

  int cyc = 0;
  always @(posedge pxl_clk) cyc <= cyc + 1;

  // Driver model: a line starts when triggerMode is low while idle; in free-run
  // it restarts at the period end as long as triggerMode is still low.
  logic act = 1'b0;
  int   ph  = 0;
  always @(posedge pxl_clk) begin
    if (!act) begin
      if (!drv_trigger_mode && rst_n) begin act <= 1'b1; ph <= 0; end
    end else if (ph >= LINE_MIN_CLKS + int'(drv_f_cnt) - 1) begin
      if (!drv_trigger_mode) ph <= 0;
      else                   act <= 1'b0;
    end else begin
      ph <= ph + 1;
    end
  end
  assign os_tvalid = act && ph >= CCD_LOAD_CLKS && ph < CCD_LOAD_CLKS + CCD_PIXELS;

  // Event monitor, sampled 1 time unit after the active edge.
  logic clr = 1'b0, tv_d = 1'b0;
  int n_rise = 0, n_fall = 0, n_fd = 0, n_ov = 0;
  int fd_lc = 0, fd_cyc = 0, last_w = 0, last_rise = 0;
  int rise_q[$];
  always @(posedge pxl_clk) begin
    #1;
    tv_d <= os_tvalid;
    if (clr) begin
      n_rise <= 0; n_fall <= 0; n_fd <= 0; n_ov <= 0;
      rise_q.delete();
    end else begin
      if (os_tvalid && !tv_d) begin
        n_rise <= n_rise + 1; last_rise <= cyc; rise_q.push_back(cyc);
      end
      if (!os_tvalid && tv_d) begin
        n_fall <= n_fall + 1; last_w <= cyc - last_rise;
      end
      if (frame_done) begin
        n_fd <= n_fd + 1; fd_lc <= int'(line_cnt); fd_cyc <= cyc;
      end
      if (trig_overrun) n_ov <= n_ov + 1;
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string name, input longint act_v, input longint exp_v);
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pxl_clk);
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(1); clr = 1'b0;
  endtask

  task automatic do_cfg(input logic ext, input logic [24:0] f, input logic [LW-1:0] l);
    cfg_ext_mode = ext; cfg_f_cnt = f; cfg_lines = l; cfg_wr = 1'b1;
    tick(1);
    cfg_wr = 1'b0;
  endtask

  task automatic do_start(); start = 1'b1; tick(1); start = 1'b0; endtask
  task automatic do_stop();  stop  = 1'b1; tick(1); stop  = 1'b0; endtask

  function automatic int cnt_of(input int which);
    case (which)
      0:       return n_rise;
      1:       return n_fall;
      default: return n_fd;
    endcase
  endfunction

  task automatic wait_cnt(input int which, input int n, input int budget, input string name);
    int k;
    k = 0;
    while (cnt_of(which) < n && k < budget) begin tick(1); k++; end
    if (cnt_of(which) < n) begin
      tests++; fails++;
      $display("FAIL %s: timed out after %0d cycles, count %0d need %0d",
               name, budget, cnt_of(which), n);
    end
  endtask

  typedef struct {
    logic [24:0] f_in;
    logic [24:0] f_exp;
  } fvec_t;
  fvec_t fv[5];

  initial begin
    #(50 * 200000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, e1, t_stop;
    fv[0] = '{25'd0,        25'd0};
    fv[1] = '{25'd100,      25'd100};
    fv[2] = '{25'd19997875, 25'd19997875};
    fv[3] = '{25'd19997876, 25'd19997875};
    fv[4] = '{25'h1FFFFFF,  25'd19997875};

    // Reset state
    tick(3);
    chk("rst_trig_mode", drv_trigger_mode, 1);
    chk("rst_ext_trig",  drv_ext_trigger, 0);
    chk("rst_f_cnt",     drv_f_cnt, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_line_cnt",  line_cnt, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun",   trig_overrun, 0);
    rst_n = 1'b1;
    tick(2);

    // Clamp and shadow-copy table, external mode so no lines run
    do_clr();
    for (int i = 0; i < 5; i++) begin
      do_cfg(1'b1, fv[i].f_in, '0);
      do_start();
      chk($sformatf("tbl%0d_f_cnt", i), drv_f_cnt, fv[i].f_exp);
      chk($sformatf("tbl%0d_busy", i), busy, 1);
      chk($sformatf("tbl%0d_trig_mode", i), drv_trigger_mode, 1);
      do_cfg(1'b1, 25'd5, '0);
      chk($sformatf("tbl%0d_f_cnt_held", i), drv_f_cnt, fv[i].f_exp);
      do_stop();
      tick(1);
      chk($sformatf("tbl%0d_frame_done", i), n_fd, i + 1);
      chk($sformatf("tbl%0d_idle", i), busy, 0);
    end
    do_start();
    chk("new_start_f_cnt", drv_f_cnt, 5);
    do_stop();
    tick(2);

    // Internal free-run, 3 lines at f_cnt=100
    do_clr();
    do_cfg(1'b0, 25'd100, 16'd3);
    do_start();
    chk("int_trig_mode", drv_trigger_mode, 0);
    wait_cnt(2, 1, 7400, "int3_frame_done");
    chk("int3_rises", n_rise, 3);
    chk("int3_fd_count", n_fd, 1);
    chk("int3_line_cnt", fd_lc, 3);
    chk("int3_busy", busy, 0);
    chk("int3_trig_mode", drv_trigger_mode, 1);
    chk("int3_width", last_w, CCD_PIXELS);
    if (rise_q.size() == 3) begin
      chk("int3_period1", rise_q[1] - rise_q[0], 2225);
      chk("int3_period2", rise_q[2] - rise_q[1], 2225);
    end else begin
      chk("int3_rise_log", rise_q.size(), 3);
    end
    tick(3000);
    chk("int3_no_4th", n_rise, 3);

    // External mode, two triggered lines
    do_clr();
    do_cfg(1'b1, 25'd0, 16'd2);
    do_start();
    tick(5);
    ext_trig = 1'b1; e0 = cyc;
    tick(1);
    chk("sync_level_lag", drv_ext_trigger, 0);
    tick(1);
    chk("sync_level", drv_ext_trigger, 1);
    tick(10);
    ext_trig = 1'b0;
    while (cyc < e0 + 5000) tick(1);
    ext_trig = 1'b1; e1 = cyc;
    tick(10);
    ext_trig = 1'b0;
    wait_cnt(2, 1, 3000, "ext2_frame_done");
    chk("ext2_rises", n_rise, 2);
    if (rise_q.size() == 2) begin
      chk("ext2_latency0", rise_q[0] - e0, 39);
      chk("ext2_latency1", rise_q[1] - e1, 39);
    end else begin
      chk("ext2_rise_log", rise_q.size(), 2);
    end
    chk("ext2_line_cnt", fd_lc, 2);
    chk("ext2_busy", busy, 0);

    // External overrun: three edges during one line
    do_clr();
    do_cfg(1'b1, 25'd0, 16'd0);
    do_start();
    for (int i = 0; i < 3; i++) begin
      ext_trig = 1'b1; tick(20);
      ext_trig = 1'b0; tick(80);
    end
    wait_cnt(0, 2, 3000, "ovr_second_line");
    chk("ovr_pulses", n_ov, 1);
    do_stop();
    wait_cnt(2, 1, 3000, "ovr_frame_done");
    chk("ovr_rises", n_rise, 2);
    chk("ovr_line_cnt", fd_lc, 2);
    chk("ovr_busy", busy, 0);

    // Internal unlimited, stop mid-line
    do_clr();
    do_cfg(1'b0, 25'd50, 16'd0);
    do_start();
    wait_cnt(0, 1, 100, "stop_first_rise");
    tick(500);
    do_stop();
    chk("stop_trig_mode", drv_trigger_mode, 1);
    chk("stop_busy_drain", busy, 1);
    wait_cnt(2, 1, 3000, "stop_frame_done");
    chk("stop_line_cnt", fd_lc, 1);
    chk("stop_falls", n_fall, 1);
    chk("stop_busy", busy, 0);
    tick(3000);
    chk("stop_no_more", n_rise, 1);

    // Stop issued between lines: drain timeout
    do_clr();
    do_cfg(1'b0, 25'd1000, 16'd0);
    do_start();
    wait_cnt(1, 1, 2400, "gap_first_fall");
    tick(10);
    t_stop = cyc;
    do_stop();
    wait_cnt(2, 1, 100, "gap_frame_done");
    chk("gap_timeout_window", (fd_cyc - t_stop >= 38 && fd_cyc - t_stop <= 44), 1);
    chk("gap_line_cnt", fd_lc, 1);
    tick(3000);
    chk("gap_no_more", n_rise, 1);

    // Reset mid-frame, then a normal run
    do_clr();
    do_cfg(1'b0, 25'd100, 16'd3);
    do_start();
    wait_cnt(0, 1, 100, "rst_first_rise");
    tick(300);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_trig_mode", drv_trigger_mode, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_line_cnt", line_cnt, 0);
    chk("mid_rst_f_cnt", drv_f_cnt, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    tick(2600);
    do_clr();
    do_cfg(1'b0, 25'd100, 16'd1);
    do_start();
    wait_cnt(2, 1, 2600, "post_rst_frame_done");
    chk("post_rst_rises", n_rise, 1);
    chk("post_rst_line_cnt", fd_lc, 1);
    chk("post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
